// File: rtl/cla_sub_pipe_16bit.sv
// Four-stage pipelined 16-bit subtractor: diff = a - b - borrow_in.
// Implemented as a + ~b + ~borrow_in, one 4-bit carry-look-ahead slice per
// stage with the inter-slice carry registered. Valid/ready stream interface;
// the whole pipeline advances in lockstep whenever the output register is
// empty or being drained.
module cla_sub_pipe_16bit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    // Fully expanded 4-bit look-ahead slice: returns {carry_out, sum}.
    function automatic logic [SLICE:0] cla4(
        input logic [SLICE-1:0] x,
        input logic [SLICE-1:0] y,
        input logic             ci
    );
        logic [SLICE-1:0] g;
        logic [SLICE-1:0] p;
        logic             c1, c2, c3, c4;
        g  = x & y;
        p  = x ^ y;
        c1 = g[0] | (p[0] & ci);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & ci);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c4, p ^ {c3, c2, c1, ci}};
    endfunction

    // Stage 0: nibble 0 plus the upper operand bits still to be consumed
    logic                   v0_q;
    logic [SLICE-1:0]       d0_q,  d0_d;
    logic [WIDTH-SLICE-1:0] a0_q,  nb0_q;
    logic                   c0_q,  c0_d;

    // Stage 1: nibbles 1..0
    logic                     v1_q;
    logic [2*SLICE-1:0]       d1_q,  d1_d;
    logic [WIDTH-2*SLICE-1:0] a1_q,  nb1_q;
    logic                     c1_q,  c1_d;

    // Stage 2: nibbles 2..0; the remaining operand bits include both sign bits
    logic               v2_q;
    logic [3*SLICE-1:0] d2_q,  d2_d;
    logic [SLICE-1:0]   a2_q,  nb2_q;
    logic               c2_q,  c2_d;

    // Stage 3: output register
    logic             v3_q;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bo_q,   bo_d;
    logic             ov_q,   ov_d;

    logic [WIDTH-1:0] b_n;
    logic [SLICE-1:0] n1, n2, n3;
    logic             c3_d;
    logic             advance;

    assign b_n      = ~b;
    assign advance  = ~v3_q | out_ready;
    assign in_ready = advance;

    // Per-stage slice arithmetic and next-state data
    always_comb begin
        {c0_d, d0_d} = cla4(a[SLICE-1:0], b_n[SLICE-1:0], ~borrow_in);
        {c1_d, n1}   = cla4(a0_q[SLICE-1:0], nb0_q[SLICE-1:0], c0_q);
        {c2_d, n2}   = cla4(a1_q[SLICE-1:0], nb1_q[SLICE-1:0], c1_q);
        {c3_d, n3}   = cla4(a2_q, nb2_q, c2_q);
        d1_d   = {n1, d0_q};
        d2_d   = {n2, d1_q};
        diff_d = {n3, d2_q};
        // Borrow is the inverted final carry of a + ~b + ~borrow_in.
        bo_d   = ~c3_d;
        // a2_q/nb2_q top bits are a[15] and ~b[15]; signs differ iff they match.
        ov_d   = (a2_q[SLICE-1] == nb2_q[SLICE-1]) && (n3[SLICE-1] != a2_q[SLICE-1]);
    end

    // Lockstep pipeline: every stage loads from its predecessor on advance
    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q   <= 1'b0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            d0_q   <= '0;
            a0_q   <= '0;
            nb0_q  <= '0;
            c0_q   <= 1'b0;
            d1_q   <= '0;
            a1_q   <= '0;
            nb1_q  <= '0;
            c1_q   <= 1'b0;
            d2_q   <= '0;
            a2_q   <= '0;
            nb2_q  <= '0;
            c2_q   <= 1'b0;
            diff_q <= '0;
            bo_q   <= 1'b0;
            ov_q   <= 1'b0;
        end else if (advance) begin
            v0_q   <= in_valid;
            d0_q   <= d0_d;
            a0_q   <= a[WIDTH-1:SLICE];
            nb0_q  <= b_n[WIDTH-1:SLICE];
            c0_q   <= c0_d;

            v1_q   <= v0_q;
            d1_q   <= d1_d;
            a1_q   <= a0_q[WIDTH-SLICE-1:SLICE];
            nb1_q  <= nb0_q[WIDTH-SLICE-1:SLICE];
            c1_q   <= c1_d;

            v2_q   <= v1_q;
            d2_q   <= d2_d;
            a2_q   <= a1_q[WIDTH-2*SLICE-1:SLICE];
            nb2_q  <= nb1_q[WIDTH-2*SLICE-1:SLICE];
            c2_q   <= c2_d;

            v3_q   <= v2_q;
            diff_q <= diff_d;
            bo_q   <= bo_d;
            ov_q   <= ov_d;
        end
    end

    assign out_valid  = v3_q;
    assign diff       = diff_q;
    assign borrow_out = bo_q;
    assign overflow   = ov_q;

endmodule
